// File: rtl/axi_lite_reg_router_if.sv
// Bundle between the AXI Lite slave's register port, the router and the peripheral banks.
// The slave modport is the router's view; master is the surrounding environment.
interface axi_lite_reg_router_if #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned PORT_ADDR_WIDTH = 8
);
  logic                            i_reg_in_rdy;
  logic                            o_reg_in_ack_stb;
  logic [ADDR_WIDTH-1:0]           i_reg_address;
  logic [DATA_WIDTH-1:0]           i_reg_in_data;
  logic                            i_reg_out_req;
  logic                            o_reg_out_rdy_stb;
  logic [DATA_WIDTH-1:0]           o_reg_out_data;
  logic                            o_reg_invalid_addr;
  logic [NUM_PORTS-1:0]            o_p_wr_stb;
  logic [NUM_PORTS-1:0]            o_p_rd_stb;
  logic [PORT_ADDR_WIDTH-1:0]      o_p_addr;
  logic [DATA_WIDTH-1:0]           o_p_wdata;
  logic [NUM_PORTS-1:0]            i_p_ack;
  logic [NUM_PORTS*DATA_WIDTH-1:0] i_p_rdata;
  logic [NUM_PORTS-1:0]            i_p_err;
  logic                            o_busy;

  modport slave (
    input  i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
    input  i_p_ack, i_p_rdata, i_p_err,
    output o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr,
    output o_p_wr_stb, o_p_rd_stb, o_p_addr, o_p_wdata, o_busy
  );

  modport master (
    output i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
    output i_p_ack, i_p_rdata, i_p_err,
    input  o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr,
    input  o_p_wr_stb, o_p_rd_stb, o_p_addr, o_p_wdata, o_busy
  );
endinterface

// File: rtl/axi_lite_reg_router.sv
// Routes one register transaction at a time to a peripheral bank selected by address
// bits, waits for its ack with a timeout and reports data plus a DECERR-style flag.
module axi_lite_reg_router #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned SEL_BITS        = 2,
  parameter int unsigned PORT_ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT         = 256
) (
  input logic                  clk,
  input logic                  rst_n,
  axi_lite_reg_router_if.slave bus
);
  localparam int unsigned TW     = $clog2(TIMEOUT);
  localparam int unsigned HI_LSB = PORT_ADDR_WIDTH + SEL_BITS;
  localparam int unsigned SW1    = SEL_BITS + 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RESPOND, RELEASE} state_t;

  state_t                     state_q, state_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [SEL_BITS-1:0]        sel_q, sel_d;
  logic                       is_wr_q, is_wr_d;
  logic [PORT_ADDR_WIDTH-1:0] p_addr_q, p_addr_d;
  logic [DATA_WIDTH-1:0]      p_wdata_q, p_wdata_d;
  logic [NUM_PORTS-1:0]       wr_stb_q, wr_stb_d;
  logic [NUM_PORTS-1:0]       rd_stb_q, rd_stb_d;
  logic                       ack_stb_q, ack_stb_d;
  logic                       rdy_stb_q, rdy_stb_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       invalid_q, invalid_d;
  logic                       busy_q, busy_d;

  logic [SEL_BITS-1:0]        dec_sel;
  logic                       dec_bad;
  logic                       ack_sel, err_sel;
  logic [DATA_WIDTH-1:0]      rdata_sel;
  logic                       first_wait;

  // Address decode of the incoming request
  always_comb begin
    dec_sel = bus.i_reg_address[PORT_ADDR_WIDTH +: SEL_BITS];
    dec_bad = ((bus.i_reg_address >> HI_LSB) != '0) ||
              ({1'b0, dec_sel} >= SW1'(NUM_PORTS));
  end

  // Response mux for the latched port; acks on any other port are ignored
  always_comb begin
    ack_sel   = 1'b0;
    err_sel   = 1'b0;
    rdata_sel = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (sel_q == SEL_BITS'(k)) begin
        ack_sel   = bus.i_p_ack[k];
        err_sel   = bus.i_p_err[k];
        rdata_sel = bus.i_p_rdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Strobe cycle does not count toward the timeout
  assign first_wait = (|wr_stb_q) | (|rd_stb_q);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    sel_d     = sel_q;
    is_wr_d   = is_wr_q;
    p_addr_d  = p_addr_q;
    p_wdata_d = p_wdata_q;
    wr_stb_d  = '0;
    rd_stb_d  = '0;
    ack_stb_d = 1'b0;
    rdy_stb_d = 1'b0;
    rdata_d   = rdata_q;
    invalid_d = invalid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_reg_in_rdy || bus.i_reg_out_req) begin
          is_wr_d = bus.i_reg_in_rdy;
          sel_d   = dec_sel;
          if (dec_bad) begin
            state_d   = RESPOND;
            invalid_d = 1'b1;
            if (bus.i_reg_in_rdy) begin
              ack_stb_d = 1'b1;
            end else begin
              rdy_stb_d = 1'b1;
              rdata_d   = '0;
            end
          end else begin
            state_d   = WAIT_ACK;
            timer_d   = '0;
            p_addr_d  = bus.i_reg_address[PORT_ADDR_WIDTH-1:0];
            p_wdata_d = bus.i_reg_in_data;
            if (bus.i_reg_in_rdy) wr_stb_d = NUM_PORTS'(1) << dec_sel;
            else                  rd_stb_d = NUM_PORTS'(1) << dec_sel;
          end
        end
      end
      WAIT_ACK: begin
        if (ack_sel) begin
          state_d   = RESPOND;
          invalid_d = err_sel;
          if (is_wr_q) begin
            ack_stb_d = 1'b1;
          end else begin
            rdy_stb_d = 1'b1;
            rdata_d   = err_sel ? '0 : rdata_sel;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d   = RESPOND;
          invalid_d = 1'b1;
          if (is_wr_q) begin
            ack_stb_d = 1'b1;
          end else begin
            rdy_stb_d = 1'b1;
            rdata_d   = '0;
          end
        end else if (!first_wait) begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESPOND: state_d = RELEASE;
      RELEASE: begin
        if (!bus.i_reg_in_rdy && !bus.i_reg_out_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      sel_q     <= '0;
      is_wr_q   <= 1'b0;
      p_addr_q  <= '0;
      p_wdata_q <= '0;
      wr_stb_q  <= '0;
      rd_stb_q  <= '0;
      ack_stb_q <= 1'b0;
      rdy_stb_q <= 1'b0;
      rdata_q   <= '0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sel_q     <= sel_d;
      is_wr_q   <= is_wr_d;
      p_addr_q  <= p_addr_d;
      p_wdata_q <= p_wdata_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      ack_stb_q <= ack_stb_d;
      rdy_stb_q <= rdy_stb_d;
      rdata_q   <= rdata_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_reg_in_ack_stb   = ack_stb_q;
  assign bus.o_reg_out_rdy_stb  = rdy_stb_q;
  assign bus.o_reg_out_data     = rdata_q;
  assign bus.o_reg_invalid_addr = invalid_q;
  assign bus.o_p_wr_stb         = wr_stb_q;
  assign bus.o_p_rd_stb         = rd_stb_q;
  assign bus.o_p_addr           = p_addr_q;
  assign bus.o_p_wdata          = p_wdata_q;
  assign bus.o_busy             = busy_q;
endmodule

// File: tb/tb_axi_lite_reg_router.sv
// Bench for axi_lite_reg_router: directed and random transactions compared against a
// transaction-level model of decode, latency, error and data rules.
module tb_axi_lite_reg_router;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned NP  = 4;
  localparam int unsigned SB  = 2;
  localparam int unsigned PAW = 8;
  localparam int unsigned TO  = 16;

  typedef struct packed {
    logic [7:0]     pulse_cyc;
    logic [7:0]     pulses;
    logic           pulse_wr;
    logic           pulse_rd;
    logic           inv;
    logic [DW-1:0]  data;
    logic [NP-1:0]  wr_stb1;
    logic [NP-1:0]  rd_stb1;
    logic [7:0]     stray;
    logic [PAW-1:0] paddr1;
    logic [PAW-1:0] paddr_p;
    logic [DW-1:0]  pwdata;
    logic [7:0]     busy_cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0]  m_rdata;
  logic [PAW-1:0] m_paddr;
  logic [DW-1:0]  m_pwdata;

  axi_lite_reg_router_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP),
                           .PORT_ADDR_WIDTH(PAW)) bus ();

  axi_lite_reg_router #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP), .SEL_BITS(SB),
                        .PORT_ADDR_WIDTH(PAW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic string fmt(obs_t o);
    return $sformatf("pc=%0d n=%0d w=%0b r=%0b inv=%0b d=%h ws=%b rs=%b stray=%0d pa=%h/%h pw=%h busy=%0d",
                     o.pulse_cyc, o.pulses, o.pulse_wr, o.pulse_rd, o.inv, o.data, o.wr_stb1,
                     o.rd_stb1, o.stray, o.paddr1, o.paddr_p, o.pwdata, o.busy_cnt);
  endfunction

  function automatic logic [DW+1+DW+NP+NP+PAW+1+1+1-1:0] all_outputs();
    return {bus.o_reg_in_ack_stb, bus.o_reg_out_rdy_stb, bus.o_reg_out_data,
            bus.o_reg_invalid_addr, bus.o_p_wr_stb, bus.o_p_rd_stb, bus.o_p_addr,
            bus.o_p_wdata, bus.o_busy};
  endfunction

  task automatic clear_inputs();
    bus.i_reg_in_rdy  = 1'b0;
    bus.i_reg_out_req = 1'b0;
    bus.i_reg_address = '0;
    bus.i_reg_in_data = '0;
    bus.i_p_ack       = '0;
    bus.i_p_err       = '0;
    bus.i_p_rdata     = '0;
  endtask

  task automatic model_reset();
    m_rdata  = '0;
    m_paddr  = '0;
    m_pwdata = '0;
  endtask

  // Transaction-level reference: decode, latency and response rules
  task automatic model_txn(input bit wr, input bit both, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int k, input bit perr,
                           input logic [DW-1:0] prdata, output obs_t e);
    logic [SB-1:0] sel;
    logic [NP-1:0] oh;
    bit valid, use_wr, err;
    int pc;
    sel    = addr[PAW +: SB];
    valid  = ((addr >> (PAW + SB)) == 0) && (int'(sel) < int'(NP));
    use_wr = wr || both;
    oh     = '0;
    oh[sel] = 1'b1;
    if (!valid)                     begin pc = 1;       err = 1'b1; end
    else if (k >= 0 && k <= int'(TO)) begin pc = 2 + k;   err = perr; end
    else                            begin pc = TO + 2;  err = 1'b1; end
    e = '0;
    if (valid) begin
      m_paddr  = addr[PAW-1:0];
      m_pwdata = wdata;
      if (use_wr) e.wr_stb1 = oh;
      else        e.rd_stb1 = oh;
    end
    if (!use_wr) m_rdata = err ? '0 : prdata;
    e.pulse_cyc = 8'(pc);
    e.pulses    = 8'd1;
    e.pulse_wr  = use_wr;
    e.pulse_rd  = !use_wr;
    e.inv       = err;
    e.data      = m_rdata;
    e.paddr1    = m_paddr;
    e.paddr_p   = m_paddr;
    e.pwdata    = m_pwdata;
    e.busy_cnt  = 8'(pc + 1);
  endtask

  // Acts as upstream slave and the peripheral banks; records what the DUT did
  task automatic run_txn(input bit wr, input bit both, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int k, input bit perr,
                         input logic [DW-1:0] prdata, input int late, input bit noise,
                         output obs_t o);
    int s, limit;
    bit drop;
    s     = int'(addr[PAW +: SB]);
    limit = TO + 10;
    drop  = 1'b0;
    o     = '0;
    @(posedge clk); #1;
    bus.i_reg_in_rdy  = wr || both;
    bus.i_reg_out_req = !wr || both;
    bus.i_reg_address = addr;
    bus.i_reg_in_data = wdata;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(posedge clk); #1;
      if (drop) begin
        bus.i_reg_in_rdy  = 1'b0;
        bus.i_reg_out_req = 1'b0;
        drop = 1'b0;
      end
      bus.i_p_ack   = '0;
      bus.i_p_err   = '0;
      bus.i_p_rdata = '0;
      if (noise) begin
        bus.i_p_ack = NP'($urandom);
        bus.i_p_err = NP'($urandom);
        for (int p = 0; p < int'(NP); p++) bus.i_p_rdata[p*DW +: DW] = $urandom;
      end
      bus.i_p_ack[s]           = (k >= 0 && cyc == 1 + k) || (cyc == late);
      bus.i_p_err[s]           = perr;
      bus.i_p_rdata[s*DW +: DW] = prdata;
      @(negedge clk);
      if (cyc == 1) begin
        o.wr_stb1 = bus.o_p_wr_stb;
        o.rd_stb1 = bus.o_p_rd_stb;
        o.paddr1  = bus.o_p_addr;
        o.pwdata  = bus.o_p_wdata;
      end else if ((|bus.o_p_wr_stb) || (|bus.o_p_rd_stb)) begin
        o.stray = o.stray + 8'd1;
      end
      if (bus.o_busy) o.busy_cnt = o.busy_cnt + 8'd1;
      if (bus.o_reg_in_ack_stb || bus.o_reg_out_rdy_stb) begin
        o.pulses = o.pulses + 8'd1;
        if (o.pulses == 8'd1) begin
          o.pulse_cyc = 8'(cyc);
          o.pulse_wr  = bus.o_reg_in_ack_stb;
          o.pulse_rd  = bus.o_reg_out_rdy_stb;
          o.inv       = bus.o_reg_invalid_addr;
          o.data      = bus.o_reg_out_data;
          o.paddr_p   = bus.o_p_addr;
          drop  = 1'b1;
          limit = (late + 1 > cyc + 3) ? late + 1 : cyc + 3;
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (all_outputs() !== '0)
      begin bad++; $display("FAIL reset_outputs got=%h required=0", all_outputs()); end
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_write_basic();
    obs_t e, o;
    model_txn(1, 0, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 32'h0, e);
    run_txn  (1, 0, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL write_basic got{%s} required{%s}", fmt(o), fmt(e)); end
  endtask

  task automatic test_read_delay();
    obs_t e, o;
    model_txn(0, 0, 32'h0000_0310, 32'h0, 5, 0, 32'h1234_5678, e);
    run_txn  (0, 0, 32'h0000_0310, 32'h0, 5, 0, 32'h1234_5678, 0, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL read_delay got{%s} required{%s}", fmt(o), fmt(e)); end
  endtask

  task automatic test_invalid();
    obs_t e, o;
    logic [AW-1:0] addrs [2];
    addrs[0] = 32'h0001_0000;
    addrs[1] = 32'h0000_0400;
    foreach (addrs[i]) begin
      model_txn(0, 0, addrs[i], 32'h5555_AAAA, -1, 0, 32'hCAFE_F00D, e);
      run_txn  (0, 0, addrs[i], 32'h5555_AAAA, -1, 0, 32'hCAFE_F00D, 0, 0, o);
      total++;
      if (o !== e) begin bad++; $display("FAIL invalid_%0d got{%s} required{%s}", i, fmt(o), fmt(e)); end
    end
    model_txn(1, 0, 32'h8000_0200, 32'h1111_2222, 0, 0, 32'h0, e);
    run_txn  (1, 0, 32'h8000_0200, 32'h1111_2222, 0, 0, 32'h0, 0, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL invalid_write got{%s} required{%s}", fmt(o), fmt(e)); end
  endtask

  task automatic test_timeout();
    obs_t e, o;
    model_txn(0, 0, 32'h0000_0220, 32'h0, -1, 0, 32'h9999_9999, e);
    run_txn  (0, 0, 32'h0000_0220, 32'h0, -1, 0, 32'h9999_9999, 20, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL timeout_read got{%s} required{%s}", fmt(o), fmt(e)); end
    // Last-chance ack is honoured; one cycle later the timeout wins
    model_txn(0, 0, 32'h0000_0108, 32'h0, TO, 0, 32'hABCD_0123, e);
    run_txn  (0, 0, 32'h0000_0108, 32'h0, TO, 0, 32'hABCD_0123, 0, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL ack_at_limit got{%s} required{%s}", fmt(o), fmt(e)); end
    model_txn(1, 0, 32'h0000_0308, 32'h7777_0000, TO + 1, 0, 32'h0, e);
    run_txn  (1, 0, 32'h0000_0308, 32'h7777_0000, TO + 1, 0, 32'h0, 0, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL ack_past_limit got{%s} required{%s}", fmt(o), fmt(e)); end
  endtask

  task automatic test_port_err();
    obs_t e, o;
    model_txn(0, 0, 32'h0000_0044, 32'h0, 2, 1, 32'hFFFF_0001, e);
    run_txn  (0, 0, 32'h0000_0044, 32'h0, 2, 1, 32'hFFFF_0001, 0, 1, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL port_err_read got{%s} required{%s}", fmt(o), fmt(e)); end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    model_txn(1, 1, 32'h0000_02F0, 32'h0BAD_CAFE, 1, 0, 32'h3333_4444, e);
    run_txn  (1, 1, 32'h0000_02F0, 32'h0BAD_CAFE, 1, 0, 32'h3333_4444, 0, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL both_req_write got{%s} required{%s}", fmt(o), fmt(e)); end
    model_txn(0, 0, 32'h0000_0001, 32'h0, 0, 0, 32'h5A5A_5A5A, e);
    run_txn  (0, 0, 32'h0000_0001, 32'h0, 0, 0, 32'h5A5A_5A5A, 0, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL next_read got{%s} required{%s}", fmt(o), fmt(e)); end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    int pulses;
    @(posedge clk); #1;
    bus.i_reg_in_rdy  = 1'b1;
    bus.i_reg_address = 32'h0000_0210;
    bus.i_reg_in_data = 32'h1357_9BDF;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (all_outputs() !== '0)
      begin bad++; $display("FAIL reset_mid_outputs got=%h required=0", all_outputs()); end
    model_reset();
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_reg_in_ack_stb || bus.o_reg_out_rdy_stb || bus.o_busy) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL reset_mid_silence got=%0d required=0", pulses); end
    model_txn(1, 0, 32'h0000_0210, 32'h2468_ACE0, 3, 0, 32'h0, e);
    run_txn  (1, 0, 32'h0000_0210, 32'h2468_ACE0, 3, 0, 32'h0, 0, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL reset_mid_recover got{%s} required{%s}", fmt(o), fmt(e)); end
  endtask

  task automatic test_random();
    obs_t e, o;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, prdata;
    bit wr, both, perr;
    int k;
    for (int n = 0; n < 40; n++) begin
      addr = {22'h0, 2'($urandom_range(0, 3)), 8'($urandom)};
      if ($urandom_range(0, 4) == 0) addr = addr | (32'h1 << $urandom_range(10, 31));
      wdata  = $urandom;
      prdata = $urandom;
      wr     = 1'($urandom);
      both   = ($urandom_range(0, 5) == 0);
      perr   = ($urandom_range(0, 3) == 0);
      k      = int'($urandom_range(0, 9));
      if (k == 9) k = -1;
      model_txn(wr, both, addr, wdata, k, perr, prdata, e);
      run_txn  (wr, both, addr, wdata, k, perr, prdata, 0, 1, o);
      total++;
      if (o !== e)
        begin bad++; $display("FAIL random_%0d addr=%h got{%s} required{%s}", n, addr, fmt(o), fmt(e)); end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_delay();
    test_invalid();
    test_timeout();
    test_port_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_lite_reg_router.md
# axi_lite_reg_router

Routes single register transactions from the AXI Lite slave's simple user interface to one of NUM_PORTS peripheral register banks. Decodes the port from address bits, strobes the selected port, and waits for its acknowledge with a timeout. Returns read data and an error flag to the slave: DECERR on bad decode, port error or timeout. Sits directly behind the AXI Lite slave, one transaction at a time.

## Interface
- ADDR_WIDTH, 32: upstream address width
- DATA_WIDTH, 32: data width
- NUM_PORTS, 4: downstream ports, 1..16
- SEL_BITS, 2: port-select field width; 2^SEL_BITS >= NUM_PORTS
- PORT_ADDR_WIDTH, 8: low address bits forwarded to ports
- TIMEOUT, 256: WAIT_ACK cycles before abort, >= 2

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_reg_in_rdy  in  1  write pending (level, held until ack)
- o_reg_in_ack_stb  out  1  write done, 1-cycle pulse
- i_reg_address  in  ADDR_WIDTH  transaction address
- i_reg_in_data  in  DATA_WIDTH  write data
- i_reg_out_req  in  1  read pending (level, held until strobe)
- o_reg_out_rdy_stb  out  1  read done, 1-cycle pulse
- o_reg_out_data  out  DATA_WIDTH  read data
- o_reg_invalid_addr  out  1  error flag, valid with either done pulse
- o_p_wr_stb  out  NUM_PORTS  one-hot write strobe
- o_p_rd_stb  out  NUM_PORTS  one-hot read strobe
- o_p_addr  out  PORT_ADDR_WIDTH  port-local address
- o_p_wdata  out  DATA_WIDTH  write data to ports
- i_p_ack  in  NUM_PORTS  per-port completion
- i_p_rdata  in  NUM_PORTS*DATA_WIDTH  per-port read data; port k at [k*DATA_WIDTH +: DATA_WIDTH]
- i_p_err  in  NUM_PORTS  per-port error, sampled with ack
- o_busy  out  1  high whenever state != IDLE

## Operation
- All outputs registered. Reset value 0 for every output. State resets to IDLE and the timer to 0.
- Decode: sel = addr[PORT_ADDR_WIDTH +: SEL_BITS]. Invalid if any bit above PORT_ADDR_WIDTH+SEL_BITS is nonzero, or if sel >= NUM_PORTS.
- IDLE:
  - i_reg_in_rdy wins if both requests are high.
  - On a request, latch address, wdata, sel and direction.
  - Invalid decode: go to RESPOND with err=1.
  - Valid decode: drive o_p_addr/o_p_wdata, set one-hot o_p_wr_stb[sel] or o_p_rd_stb[sel], clear timer, go to WAIT_ACK.
- WAIT_ACK:
  - Strobe is high in the first WAIT_ACK cycle only. o_p_addr/o_p_wdata hold until IDLE.
  - Only i_p_ack[sel] counts; acks on other ports are ignored.
  - On ack: capture err=i_p_err[sel]; on a read, capture rdata=i_p_rdata[sel], or 0 if err. Go to RESPOND.
  - Without ack the timer increments. When the timer reaches TIMEOUT-1 with no ack: err=1, read data 0, go to RESPOND. A late ack is ignored.
- RESPOND: pulse o_reg_in_ack_stb (write) or o_reg_out_rdy_stb (read) for exactly one cycle, with o_reg_invalid_addr=err and o_reg_out_data valid in that same cycle. Go to RELEASE.
- RELEASE: wait until i_reg_in_rdy=0 and i_reg_out_req=0, then go to IDLE. This prevents re-triggering on a held level.
- o_reg_out_data changes only on read completion. o_reg_invalid_addr holds its value until the next done pulse.
- rst_n low mid-transaction: next edge returns to IDLE with all strobes and pulses 0. No response is issued for the aborted transaction.

## Timing
- Request seen in IDLE at cycle 0 → port strobe at cycle 1.
- Ack at cycle 1+k (k>=0) → done pulse at cycle 2+k.
- Invalid decode: done pulse at cycle 1. No port strobe is issued.
- Timeout: done pulse TIMEOUT+1 cycles after the strobe cycle.
- Minimum spacing between transactions: done pulse, then RELEASE (1 cycle with the slave deasserting after ack), then IDLE.
- o_busy rises in the cycle after the request is seen. It falls on entry to IDLE.

## Test plan
- Write 0x0000_0104 data 0xDEADBEEF, port 1 acks same cycle as its strobe → o_p_wr_stb=0b0010 for 1 cycle, o_p_addr=0x04, o_reg_in_ack_stb at cycle 2, invalid=0.
- Read 0x0000_0310, port 3 acks 5 cycles after strobe with rdata 0x12345678 → o_reg_out_rdy_stb at cycle 7, data 0x12345678, invalid=0.
- Read 0x0001_0000 (high bits nonzero), then 0x0000_0400 with NUM_PORTS=4 → each gives a done pulse at cycle 1, invalid=1, no port strobe.
- Read port 2 with no ack, TIMEOUT=16 → done pulse at cycle 18, data 0, invalid=1; ack arriving at cycle 20 → ignored.
- Port 0 ack with i_p_err=1 on a read → invalid=1, data 0. Both requests high → write serviced first.
- Reset pulsed in WAIT_ACK → all outputs 0 next cycle, no done pulse; a new write completes normally afterwards.
